// File: rtl/bpu_tagged_btb.sv
// Tagged direct-mapped BTB: combinational IF lookup, ID-stage resolve/update/redirect, post-reset valid sweep.
// Optional counters are enabled with `define BPU_STATS_EN.
module bpu_tagged_btb #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int REG_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             ready_o,
  input  logic [REG_W-1:0] if_predict_pc_i,
  output logic             if_predict_taken_o,
  output logic [REG_W-1:0] if_predict_targetPc_o,
  input  logic             id_update_valid_i,
  input  logic             id_update_isJumpInst_i,
  input  logic [REG_W-1:0] id_update_pc_i,
  input  logic [REG_W-1:0] id_update_targetPc_i,
  input  logic             id_update_taken_i,
  output logic             if_predict_failed_o,
  output logic [REG_W-1:0] if_flush_pc_o,
  output logic [31:0]      stat_branches_o,
  output logic [31:0]      stat_miss_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W-1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             flush_q;
  entry_t           tbl_q [ENTRIES];

  logic             run;
  logic [IDX_W-1:0] idx_f, idx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  entry_t           ent_f, ent_u;
  logic             hit_f, hit_u, pred_u, tgt_bad, mispred, upd;
  logic [CNT_W-1:0] cnt_inc, cnt_dec;

  assign run     = (state == RUN);
  assign ready_o = run;

  // IF lookup
  assign idx_f = if_predict_pc_i[IDX_W+1:2];
  assign tag_f = if_predict_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ent_f = tbl_q[idx_f];
  assign hit_f = ent_f.valid && (ent_f.tag == tag_f);

  assign if_predict_taken_o    = run && hit_f && ent_f.cnt[CNT_W-1];
  assign if_predict_targetPc_o = run ? ent_f.target : '0;

  // ID resolve: the prediction is recomputed from the entry at the ID pc
  assign idx_u   = id_update_pc_i[IDX_W+1:2];
  assign tag_u   = id_update_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ent_u   = tbl_q[idx_u];
  assign hit_u   = ent_u.valid && (ent_u.tag == tag_u);
  assign pred_u  = hit_u && ent_u.cnt[CNT_W-1];
  assign tgt_bad = pred_u && id_update_taken_i && (ent_u.target != id_update_targetPc_i);
  assign mispred = id_update_isJumpInst_i ? ((pred_u != id_update_taken_i) || tgt_bad) : pred_u;
  // The slot right after a redirect is wrong-path and must not train or redirect
  assign upd     = id_update_valid_i && !flush_q && run;

  assign if_predict_failed_o = upd && mispred;
  assign if_flush_pc_o = !run ? '0 :
                         (id_update_taken_i && id_update_isJumpInst_i) ? id_update_targetPc_i :
                         id_update_pc_i + REG_W'(4);

  assign cnt_inc = (ent_u.cnt == CNT_MAX) ? ent_u.cnt : ent_u.cnt + 1'b1;
  assign cnt_dec = (ent_u.cnt == '0)      ? ent_u.cnt : ent_u.cnt - 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= INIT;
      ptr     <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= if_predict_failed_o;
      if (state == INIT) begin
        ptr <= ptr + 1'b1;
        if (ptr == IDX_W'(ENTRIES-1)) state <= RUN;
      end
    end
  end

  // Table: swept during INIT, trained by qualified ID updates in RUN
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state == INIT) begin
        tbl_q[ptr].valid <= 1'b0;
        tbl_q[ptr].cnt   <= '0;
      end else if (upd) begin
        if (id_update_isJumpInst_i) begin
          if (id_update_taken_i) begin
            if (hit_u) begin
              tbl_q[idx_u].cnt    <= cnt_inc;
              tbl_q[idx_u].target <= id_update_targetPc_i;
            end else begin
              tbl_q[idx_u] <= '{valid: 1'b1, tag: tag_u, target: id_update_targetPc_i, cnt: CNT_WEAK};
            end
          end else if (hit_u) begin
            tbl_q[idx_u].cnt <= cnt_dec;
          end
        end else if (hit_u) begin
          // a non-branch matched an entry: the entry is an alias, drop it
          tbl_q[idx_u].valid <= 1'b0;
        end
      end
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_q, miss_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      if (upd && id_update_isJumpInst_i && (br_q != 32'hFFFF_FFFF)) br_q <= br_q + 32'd1;
      if (if_predict_failed_o && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end
  assign stat_branches_o = br_q;
  assign stat_miss_o     = miss_q;
`else
  assign stat_branches_o = '0;
  assign stat_miss_o     = '0;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_predict_pc_i[REG_W-1:IDX_W+TAG_W+2], if_predict_pc_i[1:0]};

endmodule

// File: tb/tb_bpu_tagged_btb.sv
// Directed-vector bench for bpu_tagged_btb (64 entries, 8-bit tag, 2-bit counters).
module tb_bpu_tagged_btb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_tgt;
  logic        u_valid, u_jump, u_taken;
  logic [31:0] u_pc, u_tgt;
  logic        failed;
  logic [31:0] flush_pc;
  logic [31:0] st_br, st_miss;

  int errs   = 0;
  int checks = 0;

  localparam logic [31:0] PC_A  = 32'h8000_0010;
  localparam logic [31:0] PC_AL = 32'h8000_1010;
  localparam logic [31:0] PC_B  = 32'h8000_0040;
  localparam logic [31:0] PC_C  = 32'h8000_0080;

  always #5 clk = ~clk;

  bpu_tagged_btb dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .ready_o                (ready),
    .if_predict_pc_i        (lk_pc),
    .if_predict_taken_o     (lk_taken),
    .if_predict_targetPc_o  (lk_tgt),
    .id_update_valid_i      (u_valid),
    .id_update_isJumpInst_i (u_jump),
    .id_update_pc_i         (u_pc),
    .id_update_targetPc_i   (u_tgt),
    .id_update_taken_i      (u_taken),
    .if_predict_failed_o    (failed),
    .if_flush_pc_o          (flush_pc),
    .stat_branches_o        (st_br),
    .stat_miss_o            (st_miss)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic j, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic tk);
    u_valid = v; u_jump = j; u_pc = pc; u_tgt = tgt; u_taken = tk;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    lk_pc = PC_A;
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    // an update offered during the sweep must be ignored
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b1);
    #1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      checks++;
      if (lk_taken !== 1'b0 || failed !== 1'b0 || flush_pc !== 32'h0 || lk_tgt !== 32'h0) begin
        errs++;
        $display("FAIL init_outputs: taken=%b failed=%b flush=%h tgt=%h required all 0", lk_taken, failed, flush_pc, lk_tgt);
      end
      n++;
      step();
    end
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (n !== 64) begin errs++; $display("FAIL init_length: got %0d cycles required 64", n); end
    step();
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b1);
    lk_pc = PC_A;
    #1;
    checks++;
    if (lk_taken !== 1'b0) begin errs++; $display("FAIL alloc_pre_lookup: taken=%b required 0", lk_taken); end
    checks++;
    if (failed !== 1'b1 || flush_pc !== 32'h8000_0100) begin
      errs++; $display("FAIL alloc_redirect: failed=%b flush=%h required 1 80000100", failed, flush_pc);
    end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++;
    if (lk_taken !== 1'b1 || lk_tgt !== 32'h8000_0100) begin
      errs++; $display("FAIL alloc_lookup: taken=%b tgt=%h required 1 80000100", lk_taken, lk_tgt);
    end
    step();
  endtask

  task automatic test_not_taken();
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b0);
    #1;
    checks++;
    if (failed !== 1'b1 || flush_pc !== 32'h8000_0014) begin
      errs++; $display("FAIL nt_first: failed=%b flush=%h required 1 80000014", failed, flush_pc);
    end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    lk_pc = PC_A;
    #1;
    checks++;
    if (lk_taken !== 1'b0) begin errs++; $display("FAIL nt_cnt1_lookup: taken=%b required 0", lk_taken); end
    step();
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b0);
    #1;
    checks++;
    if (failed !== 1'b0) begin errs++; $display("FAIL nt_second: failed=%b required 0", failed); end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
`ifdef BPU_STATS_EN
    checks++;
    if (st_br !== 32'd3 || st_miss !== 32'd2) begin
      errs++; $display("FAIL stats: branches=%0d miss=%0d required 3 2", st_br, st_miss);
    end
`else
    checks++;
    if (st_br !== 32'd0 || st_miss !== 32'd0) begin
      errs++; $display("FAIL stats_tied: branches=%0d miss=%0d required 0 0", st_br, st_miss);
    end
`endif
    step();
  endtask

  task automatic test_target_change();
    // cnt 0 -> 1 -> 2 -> 3, then a new target with the counter held at max
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b1);
    #1;
    checks++;
    if (failed !== 1'b1) begin errs++; $display("FAIL train_cnt0: failed=%b required 1", failed); end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b1);
    #1;
    checks++;
    if (failed !== 1'b1) begin errs++; $display("FAIL train_cnt1: failed=%b required 1", failed); end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0100, 1'b1);
    #1;
    checks++;
    if (failed !== 1'b0) begin errs++; $display("FAIL train_cnt2: failed=%b required 0", failed); end
    step();
    set_upd(1'b1, 1'b1, PC_A, 32'h8000_0200, 1'b1);
    #1;
    checks++;
    if (failed !== 1'b1 || flush_pc !== 32'h8000_0200) begin
      errs++; $display("FAIL target_mismatch: failed=%b flush=%h required 1 80000200", failed, flush_pc);
    end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    lk_pc = PC_A;
    #1;
    checks++;
    if (lk_taken !== 1'b1 || lk_tgt !== 32'h8000_0200) begin
      errs++; $display("FAIL sat_lookup: taken=%b tgt=%h required 1 80000200", lk_taken, lk_tgt);
    end
    step();
  endtask

  task automatic test_alias();
    lk_pc = PC_AL;
    set_upd(1'b1, 1'b0, PC_A, 32'h0, 1'b0);
    #1;
    checks++;
    if (lk_taken !== 1'b0) begin errs++; $display("FAIL alias_lookup: taken=%b required 0", lk_taken); end
    checks++;
    if (failed !== 1'b1 || flush_pc !== 32'h8000_0014) begin
      errs++; $display("FAIL alias_nonjump: failed=%b flush=%h required 1 80000014", failed, flush_pc);
    end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    lk_pc = PC_A;
    #1;
    checks++;
    if (lk_taken !== 1'b0) begin errs++; $display("FAIL alias_invalidated: taken=%b required 0", lk_taken); end
    step();
  endtask

  task automatic test_back_to_back();
    set_upd(1'b1, 1'b1, PC_B, 32'h8000_0400, 1'b1);
    #1;
    checks++;
    if (failed !== 1'b1) begin errs++; $display("FAIL b2b_first: failed=%b required 1", failed); end
    step();
    set_upd(1'b1, 1'b1, PC_C, 32'h8000_0800, 1'b1);
    #1;
    checks++;
    if (failed !== 1'b0) begin errs++; $display("FAIL b2b_shadow: failed=%b required 0", failed); end
    step();
    set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    lk_pc = PC_C;
    #1;
    checks++;
    if (lk_taken !== 1'b0) begin errs++; $display("FAIL b2b_no_write: taken=%b required 0", lk_taken); end
    lk_pc = PC_B;
    #1;
    checks++;
    if (lk_taken !== 1'b1 || lk_tgt !== 32'h8000_0400) begin
      errs++; $display("FAIL b2b_first_written: taken=%b tgt=%h required 1 80000400", lk_taken, lk_tgt);
    end
    step();
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (30) step();
    checks++;
    if (ready !== 1'b0) begin errs++; $display("FAIL midsweep_ready: ready=%b required 0", ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n !== 64) begin errs++; $display("FAIL midsweep_length: got %0d cycles required 64", n); end
    lk_pc = PC_B;
    #1;
    checks++;
    if (lk_taken !== 1'b0) begin errs++; $display("FAIL sweep_cleared: taken=%b required 0", lk_taken); end
    step();
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken();
    test_target_change();
    test_alias();
    test_back_to_back();
    test_mid_sweep_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
